bus_initiator: RTL and testbench
================================

BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 SHALL have parameter WORDSIZE, default 16, data/operand width.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum cycles bus_valid is held awaiting ack; legal range 2..255.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  upstream command present.
REQ-006 SHALL have port req_ready  output  1  block can accept a command.
REQ-007 SHALL have port req_unit  input  4  target bus unit ID.
REQ-008 SHALL have port req_op  input  4  unit operation code (ALU op codes when target is ALU).
REQ-009 SHALL have port req_a, req_b  input  WORDSIZE each  operands.
REQ-010 SHALL have port bus_valid  output  1  transaction driven on the unit bus.
REQ-011 SHALL have ports bus_unit (4), bus_op (4), bus_a, bus_b (WORDSIZE)  output  latched command fields.
REQ-012 SHALL have port bus_ack  input  1  responding unit completes.
REQ-013 SHALL have port bus_ack_unit  input  4  ID of responding unit.
REQ-014 SHALL have ports bus_data (WORDSIZE), bus_flags (8)  input  result word and flag vector (bit 0 carry, 1 zero, 2 equal, 3 greater, 4 less, 5 borrow, 6 reserved, 7 unused).
REQ-015 SHALL have port rsp_valid  output  1  response available.
REQ-016 SHALL have port rsp_ready  input  1  upstream consumes response.
REQ-017 SHALL have ports rsp_data (WORDSIZE), rsp_flags (8), rsp_err (2)  output  result, flags, status (00 ok, 01 timeout, 10 bad unit).

Function
REQ-018 SHALL implement states IDLE, WAIT, RESP; exactly one transaction in flight.
REQ-019 SHALL assert req_ready only in IDLE; a command is accepted on an edge where req_valid and req_ready are both 1, capturing unit, op, a, b.
REQ-020 SHALL treat unit IDs 1 (ALU), 2 (register file), 3 (debug) as valid; any other ID (0, 4 reserved, 5..15) SHALL go IDLE->RESP with rsp_err=10, rsp_data=0, rsp_flags=0, and bus_valid never asserted.
REQ-021 SHALL, for a valid ID, go IDLE->WAIT and hold bus_valid=1 with stable bus_unit/op/a/b for every WAIT cycle.
REQ-022 SHALL complete WAIT on an edge where bus_ack=1 and bus_ack_unit equals the latched unit: capture bus_data, bus_flags, set rsp_err=00, go RESP.
REQ-023 SHALL ignore bus_ack when bus_ack_unit mismatches, and ignore bus_ack in IDLE or RESP.
REQ-024 SHALL keep a wait counter cleared on WAIT entry, incremented each WAIT cycle without matching ack; when counter equals TIMEOUT-1 and no matching ack, go RESP with rsp_err=01, rsp_data=0, rsp_flags=0 (bus_valid high exactly TIMEOUT cycles).
REQ-025 SHALL give a matching ack priority over timeout in the same cycle.
REQ-026 SHALL hold rsp_valid=1 and response fields stable in RESP until an edge with rsp_ready=1, then go IDLE; req_ready rises the cycle after.
REQ-027 SHALL achieve minimum latency: accept at edge N, bus_valid high in cycle N+1, ack sampled at edge N+1, rsp_valid high in cycle N+2.
REQ-028 SHALL drive bus_unit/op/a/b to 0 whenever bus_valid=0.

Reset
REQ-029 SHALL on rst=1, asynchronously and regardless of state, enter IDLE: req_ready=1 after release, bus_valid=0, bus fields 0, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=00, counter 0.
REQ-030 SHALL abandon any in-flight transaction on reset with no response generated.

Verification
REQ-031 ALU ADD: req unit=1 op=0 a=0x0005 b=0x0003, ack next cycle with data=0x0008 flags=0x00 -> rsp_valid at N+2, rsp_data=0x0008, rsp_err=00.
REQ-032 Bad unit: req unit=4 -> bus_valid stays 0, rsp_valid next cycle, rsp_err=10, rsp_data=0.
REQ-033 Timeout: req unit=2, no ack -> bus_valid high exactly 16 cycles, then rsp_err=01; wrong-ID ack (unit=3) mid-wait ignored.
REQ-034 Backpressure: ALU CMP result flags=0x04, rsp_ready low 5 cycles -> rsp_valid, data, flags stable, req_ready=0 throughout; new req accepted only after handshake.
REQ-035 Ack on final timeout cycle (cycle 16) with data=0xBEEF -> rsp_err=00, rsp_data=0xBEEF.
REQ-036 Reset asserted mid-WAIT -> bus_valid drops immediately, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/bus_initiator_if.sv
// Command/bus/response bundle for the unit-bus initiator.
// master = initiator side, slave = the upstream/unit side driving its inputs.
interface bus_initiator_if #(
   parameter int WORDSIZE = 16
);
   logic                req_valid;
   logic                req_ready;
   logic [3:0]          req_unit;
   logic [3:0]          req_op;
   logic [WORDSIZE-1:0] req_a;
   logic [WORDSIZE-1:0] req_b;

   logic                bus_valid;
   logic [3:0]          bus_unit;
   logic [3:0]          bus_op;
   logic [WORDSIZE-1:0] bus_a;
   logic [WORDSIZE-1:0] bus_b;
   logic                bus_ack;
   logic [3:0]          bus_ack_unit;
   logic [WORDSIZE-1:0] bus_data;
   logic [7:0]          bus_flags;

   logic                rsp_valid;
   logic                rsp_ready;
   logic [WORDSIZE-1:0] rsp_data;
   logic [7:0]          rsp_flags;
   logic [1:0]          rsp_err;

   modport master (
      input  req_valid, req_unit, req_op, req_a, req_b,
      output req_ready,
      output bus_valid, bus_unit, bus_op, bus_a, bus_b,
      input  bus_ack, bus_ack_unit, bus_data, bus_flags,
      output rsp_valid, rsp_data, rsp_flags, rsp_err,
      input  rsp_ready
   );

   modport slave (
      output req_valid, req_unit, req_op, req_a, req_b,
      input  req_ready,
      input  bus_valid, bus_unit, bus_op, bus_a, bus_b,
      output bus_ack, bus_ack_unit, bus_data, bus_flags,
      input  rsp_valid, rsp_data, rsp_flags, rsp_err,
      output rsp_ready
   );
endinterface

// File: rtl/bus_initiator.sv
// Single-outstanding unit-bus initiator: accepts a command, drives it on the
// unit bus until the addressed unit acks or a timeout expires, then returns a response.
module bus_initiator #(
   parameter int WORDSIZE = 16,
   parameter int TIMEOUT  = 16
) (
   input  logic            clk,
   input  logic            rst,
   bus_initiator_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_BADUNIT = 2'b10;

   // Only the ALU, register file and debug units exist on the bus.
   function automatic logic unit_valid(input logic [3:0] unit);
      unit_valid = (unit == 4'd1) || (unit == 4'd2) || (unit == 4'd3);
   endfunction

   state_t              state_r;
   logic                req_ready_r;
   logic                bus_valid_r;
   logic [3:0]          bus_unit_r;
   logic [3:0]          bus_op_r;
   logic [WORDSIZE-1:0] bus_a_r;
   logic [WORDSIZE-1:0] bus_b_r;
   logic                rsp_valid_r;
   logic [WORDSIZE-1:0] rsp_data_r;
   logic [7:0]          rsp_flags_r;
   logic [1:0]          rsp_err_r;
   logic [7:0]          wait_cnt_r;
   logic                ack_match_s;

   // Ack counts only when it comes from the unit currently being addressed.
   always_comb begin
      ack_match_s = 1'b0;
      if (bus.bus_ack && (bus.bus_ack_unit == bus_unit_r)) begin
         ack_match_s = 1'b1;
      end else begin
         ack_match_s = 1'b0;
      end
   end

   // Transaction FSM; all outputs are registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         req_ready_r <= 1'b1;
         bus_valid_r <= 1'b0;
         bus_unit_r  <= 4'd0;
         bus_op_r    <= 4'd0;
         bus_a_r     <= {WORDSIZE{1'b0}};
         bus_b_r     <= {WORDSIZE{1'b0}};
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= {WORDSIZE{1'b0}};
         rsp_flags_r <= 8'd0;
         rsp_err_r   <= ERR_OK;
         wait_cnt_r  <= 8'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.req_valid && req_ready_r) begin
                  req_ready_r <= 1'b0;
                  if (unit_valid(bus.req_unit)) begin
                     state_r     <= WAIT;
                     bus_valid_r <= 1'b1;
                     bus_unit_r  <= bus.req_unit;
                     bus_op_r    <= bus.req_op;
                     bus_a_r     <= bus.req_a;
                     bus_b_r     <= bus.req_b;
                     wait_cnt_r  <= 8'd0;
                  end else begin
                     // Unknown unit: answer directly, never touch the bus.
                     state_r     <= RESP;
                     rsp_valid_r <= 1'b1;
                     rsp_data_r  <= {WORDSIZE{1'b0}};
                     rsp_flags_r <= 8'd0;
                     rsp_err_r   <= ERR_BADUNIT;
                  end
               end else begin
                  req_ready_r <= 1'b1;
               end
            end

            WAIT: begin
               if (ack_match_s || (wait_cnt_r == WAIT_LAST)) begin
                  state_r     <= RESP;
                  bus_valid_r <= 1'b0;
                  bus_unit_r  <= 4'd0;
                  bus_op_r    <= 4'd0;
                  bus_a_r     <= {WORDSIZE{1'b0}};
                  bus_b_r     <= {WORDSIZE{1'b0}};
                  rsp_valid_r <= 1'b1;
                  wait_cnt_r  <= 8'd0;
                  // A matching ack wins even on the last allowed cycle.
                  if (ack_match_s) begin
                     rsp_data_r  <= bus.bus_data;
                     rsp_flags_r <= bus.bus_flags;
                     rsp_err_r   <= ERR_OK;
                  end else begin
                     rsp_data_r  <= {WORDSIZE{1'b0}};
                     rsp_flags_r <= 8'd0;
                     rsp_err_r   <= ERR_TIMEOUT;
                  end
               end else begin
                  wait_cnt_r <= wait_cnt_r + 8'd1;
               end
            end

            RESP: begin
               if (bus.rsp_ready) begin
                  state_r     <= IDLE;
                  req_ready_r <= 1'b1;
                  rsp_valid_r <= 1'b0;
                  rsp_data_r  <= {WORDSIZE{1'b0}};
                  rsp_flags_r <= 8'd0;
                  rsp_err_r   <= ERR_OK;
               end else begin
                  rsp_valid_r <= 1'b1;
               end
            end

            default: begin
               state_r     <= IDLE;
               req_ready_r <= 1'b1;
               bus_valid_r <= 1'b0;
               bus_unit_r  <= 4'd0;
               bus_op_r    <= 4'd0;
               bus_a_r     <= {WORDSIZE{1'b0}};
               bus_b_r     <= {WORDSIZE{1'b0}};
               rsp_valid_r <= 1'b0;
               rsp_data_r  <= {WORDSIZE{1'b0}};
               rsp_flags_r <= 8'd0;
               rsp_err_r   <= ERR_OK;
               wait_cnt_r  <= 8'd0;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_r;
   assign bus.bus_valid = bus_valid_r;
   assign bus.bus_unit  = bus_unit_r;
   assign bus.bus_op    = bus_op_r;
   assign bus.bus_a     = bus_a_r;
   assign bus.bus_b     = bus_b_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_data  = rsp_data_r;
   assign bus.rsp_flags = rsp_flags_r;
   assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: ALU op, bad unit, timeout, backpressure,
// ack on the last timeout cycle, and reset during a transaction.
module tb_bus_initiator;

   logic clk;
   logic rst;
   int   vectors;
   int   errors;

   bus_initiator_if #(.WORDSIZE(16)) bif ();

   bus_initiator #(.WORDSIZE(16), .TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] unit, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b);
      bif.req_valid = 1'b1;
      bif.req_unit  = unit;
      bif.req_op    = op;
      bif.req_a     = a;
      bif.req_b     = b;
   endtask

   task automatic ack(input logic on, input logic [3:0] unit,
                      input logic [15:0] data, input logic [7:0] flags);
      bif.bus_ack      = on;
      bif.bus_ack_unit = unit;
      bif.bus_data     = data;
      bif.bus_flags    = flags;
   endtask

   // Watchdog so a stuck run still ends.
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int  hi;
      logic ok;
      vectors = 0;
      errors  = 0;
      rst = 1'b1;
      bif.req_valid = 1'b0;
      bif.req_unit  = 4'd0;
      bif.req_op    = 4'd0;
      bif.req_a     = 16'd0;
      bif.req_b     = 16'd0;
      bif.rsp_ready = 1'b0;
      ack(1'b0, 4'd0, 16'd0, 8'd0);

      // Reset state
      tick();
      tick();
      chk("rst_req_ready", bif.req_ready, 1'b1);
      chk("rst_bus_valid", bif.bus_valid, 1'b0);
      chk("rst_rsp_valid", bif.rsp_valid, 1'b0);
      chk("rst_rsp_fields", {bif.rsp_err, bif.rsp_flags, bif.rsp_data}, 26'd0);
      rst = 1'b0;
      tick();

      // Ack while idle is ignored
      ack(1'b1, 4'd1, 16'h1111, 8'hFF);
      tick();
      chk("idle_ack_rsp_valid", bif.rsp_valid, 1'b0);
      chk("idle_ack_req_ready", bif.req_ready, 1'b1);
      ack(1'b0, 4'd0, 16'd0, 8'd0);

      // ALU ADD with minimum latency
      send(4'd1, 4'd0, 16'h0005, 16'h0003);
      tick();
      chk("add_bus_valid", bif.bus_valid, 1'b1);
      chk("add_bus_fields", {bif.bus_unit, bif.bus_op, bif.bus_a, bif.bus_b}, {4'd1, 4'd0, 16'h0005, 16'h0003});
      chk("add_req_ready", bif.req_ready, 1'b0);
      bif.req_valid = 1'b0;
      ack(1'b1, 4'd1, 16'h0008, 8'h00);
      tick();
      chk("add_rsp_valid", bif.rsp_valid, 1'b1);
      chk("add_rsp_data", bif.rsp_data, 16'h0008);
      chk("add_rsp_err", bif.rsp_err, 2'b00);
      chk("add_bus_idle", {bif.bus_valid, bif.bus_unit, bif.bus_a}, 21'd0);
      ack(1'b0, 4'd0, 16'd0, 8'd0);
      bif.rsp_ready = 1'b1;
      tick();
      chk("add_done", {bif.rsp_valid, bif.req_ready}, 2'b01);
      bif.rsp_ready = 1'b0;

      // Bad unit
      send(4'd4, 4'd3, 16'h00AA, 16'h0055);
      tick();
      bif.req_valid = 1'b0;
      chk("bad_bus_valid", bif.bus_valid, 1'b0);
      chk("bad_rsp", {bif.rsp_valid, bif.rsp_err, bif.rsp_flags, bif.rsp_data}, {1'b1, 2'b10, 8'd0, 16'd0});
      bif.rsp_ready = 1'b1;
      tick();
      chk("bad_done", {bif.rsp_valid, bif.req_ready}, 2'b01);
      bif.rsp_ready = 1'b0;

      // Timeout with a wrong-unit ack in the middle
      send(4'd2, 4'd1, 16'h1234, 16'h0000);
      tick();
      bif.req_valid = 1'b0;
      hi = 0;
      ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (bif.rsp_valid) break;
         if (bif.bus_valid) hi++;
         if ({bif.bus_unit, bif.bus_op, bif.bus_a} !== {4'd2, 4'd1, 16'h1234}) ok = 1'b0;
         ack(hi == 5, 4'd3, 16'hDEAD, 8'h01);
         tick();
      end
      ack(1'b0, 4'd0, 16'd0, 8'd0);
      chk("to_rsp_valid", bif.rsp_valid, 1'b1);
      chk("to_bus_cycles", hi, 16);
      chk("to_bus_stable", ok, 1'b1);
      chk("to_rsp", {bif.rsp_err, bif.rsp_flags, bif.rsp_data}, {2'b01, 8'd0, 16'd0});
      bif.rsp_ready = 1'b1;
      tick();
      bif.rsp_ready = 1'b0;

      // Backpressure on a CMP result; a new request waits for the handshake
      send(4'd1, 4'd7, 16'h0009, 16'h0009);
      tick();
      ack(1'b1, 4'd1, 16'h0000, 8'h04);
      send(4'd1, 4'd2, 16'h000A, 16'h000B);
      tick();
      ack(1'b0, 4'd0, 16'd0, 8'd0);
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if ({bif.rsp_valid, bif.rsp_flags, bif.rsp_data, bif.rsp_err, bif.req_ready, bif.bus_valid}
             !== {1'b1, 8'h04, 16'h0000, 2'b00, 1'b0, 1'b0}) ok = 1'b0;
         tick();
      end
      chk("bp_stable", ok, 1'b1);
      bif.rsp_ready = 1'b1;
      tick();
      bif.rsp_ready = 1'b0;
      chk("bp_release", {bif.rsp_valid, bif.req_ready, bif.bus_valid}, 3'b010);
      tick();
      bif.req_valid = 1'b0;
      chk("bp_new_accept", {bif.bus_valid, bif.bus_op, bif.bus_a, bif.bus_b}, {1'b1, 4'd2, 16'h000A, 16'h000B});

      // Matching ack on the final (16th) wait cycle beats the timeout
      repeat (15) tick();
      chk("last_bus_valid", bif.bus_valid, 1'b1);
      ack(1'b1, 4'd1, 16'hBEEF, 8'h00);
      tick();
      ack(1'b0, 4'd0, 16'd0, 8'd0);
      chk("last_rsp", {bif.rsp_valid, bif.rsp_err, bif.rsp_data}, {1'b1, 2'b00, 16'hBEEF});
      bif.rsp_ready = 1'b1;
      tick();
      bif.rsp_ready = 1'b0;

      // Reset in the middle of WAIT
      send(4'd3, 4'd5, 16'h00C3, 16'h003C);
      tick();
      bif.req_valid = 1'b0;
      tick();
      chk("mid_bus_valid", bif.bus_valid, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst_drop", {bif.bus_valid, bif.bus_unit, bif.rsp_valid}, 6'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("mid_rst_after", {bif.req_ready, bif.rsp_valid, bif.bus_valid}, 3'b100);
      tick();
      chk("mid_rst_no_rsp", bif.rsp_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
